// File: rtl/egg_timer_pkg.sv
// Shared types and widths for the egg timer controller and its MM:SS counter.
package egg_timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int SEC_MAX = 59;
   localparam int MIN_W   = 7;
   localparam int SEC_W   = 6;

endpackage

// File: rtl/egg_timer_mmss_counter.sv
// MM:SS countdown register: increments fields independently (no carry), decrements
// with borrow, and flags zero / about-to-reach-zero for the sequencer.
module egg_timer_mmss_counter
   import egg_timer_pkg::*;
#(
   parameter int MAX_MIN = 99
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc_min,
   input  logic             inc_sec,
   input  logic             dec,
   output logic [MIN_W-1:0] minutes,
   output logic [SEC_W-1:0] seconds,
   output logic             is_zero,
   output logic             dec_to_zero
);

   assign is_zero     = (minutes == '0) && (seconds == '0);
   assign dec_to_zero = (minutes == '0) && (seconds == SEC_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement or process ordering.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         minutes <= '0;
         seconds <= '0;
      end else if (clr) begin
         minutes <= '0;
         seconds <= '0;
      end else if (dec && !is_zero) begin
         if (seconds == '0) begin
            minutes <= minutes - 1'b1;
            seconds <= SEC_W'(SEC_MAX);
         end else begin
            seconds <= seconds - 1'b1;
         end
      end else begin
         // Both fields may step in the same cycle; seconds never carries into minutes.
         if (inc_min)
            minutes <= (minutes == MIN_W'(MAX_MIN)) ? '0 : minutes + 1'b1;
         if (inc_sec)
            seconds <= (seconds == SEC_W'(SEC_MAX)) ? '0 : seconds + 1'b1;
      end
   end

endmodule

// File: rtl/egg_timer_controller.sv
// Egg timer sequencer: button handling, divider gating, tick edge detection,
// countdown control and alarm duration. All outputs are registered.
module egg_timer_controller
   import egg_timer_pkg::*;
#(
   parameter int MAX_MIN     = 99,
   parameter int ALARM_TICKS = 10
) (
   input  logic       CLK,
   input  logic       reset_n,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       inc_min,
   input  logic       inc_sec,
   input  logic       tick_in,
   output logic       div_enable,
   output logic [6:0] minutes,
   output logic [5:0] seconds,
   output logic       running,
   output logic       alarm,
   output logic       done_pulse,
   output logic [1:0] state
);

   localparam int CNT_W = $clog2(ALARM_TICKS + 1);

   state_t           state_q, state_d;
   logic             tick_q, tick;
   logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
   logic             cnt_clr, cnt_inc_min, cnt_inc_sec, cnt_dec;
   logic             is_zero, dec_to_zero, done_d;

   assign tick  = tick_in & ~tick_q;
   assign state = state_q;

   egg_timer_mmss_counter #(
      .MAX_MIN (MAX_MIN)
   ) u_mmss (
      .CLK         (CLK),
      .reset_n     (reset_n),
      .clr         (cnt_clr),
      .inc_min     (cnt_inc_min),
      .inc_sec     (cnt_inc_sec),
      .dec         (cnt_dec),
      .minutes     (minutes),
      .seconds     (seconds),
      .is_zero     (is_zero),
      .dec_to_zero (dec_to_zero)
   );

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      alarm_cnt_d = alarm_cnt_q;
      cnt_clr     = 1'b0;
      cnt_inc_min = 1'b0;
      cnt_inc_sec = 1'b0;
      cnt_dec     = 1'b0;
      done_d      = 1'b0;

      if (clear) begin
         state_d     = IDLE;
         cnt_clr     = 1'b1;
         alarm_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_inc_min = inc_min;
               cnt_inc_sec = inc_sec;
               if (start_stop && !is_zero)
                  state_d = RUN;
            end
            RUN: begin
               // A tick coinciding with start_stop still decrements; reaching zero wins over pause.
               if (tick) begin
                  cnt_dec = 1'b1;
                  if (dec_to_zero) begin
                     state_d     = DONE;
                     done_d      = 1'b1;
                     alarm_cnt_d = '0;
                  end else if (start_stop) begin
                     state_d = PAUSE;
                  end
               end else if (start_stop) begin
                  state_d = PAUSE;
               end
            end
            PAUSE: begin
               if (start_stop)
                  state_d = RUN;
            end
            DONE: begin
               if (start_stop) begin
                  state_d = IDLE;
               end else if (tick) begin
                  if (alarm_cnt_q == CNT_W'(ALARM_TICKS - 1))
                     state_d = IDLE;
                  else
                     alarm_cnt_d = alarm_cnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         tick_q      <= 1'b0;
         alarm_cnt_q <= '0;
         div_enable  <= 1'b0;
         running     <= 1'b0;
         alarm       <= 1'b0;
         done_pulse  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_in;
         alarm_cnt_q <= alarm_cnt_d;
         div_enable  <= (state_d == RUN) || (state_d == DONE);
         running     <= (state_d == RUN);
         alarm       <= (state_d == DONE);
         done_pulse  <= done_d;
      end
   end

endmodule
